ram2_ctrl: RTL

- Bus initiator for external SRAM bank RAM2, replacing the behavioural RAM2 model in the synthesised design.
- Arbitrates the instruction-fetch (IF) and memory-stage (MEM) requests onto one asynchronous SRAM port.
- Sequences the chip-enable, output-enable and write-enable strobes across multiple cycles.
- Returns fetched instructions and load data, and raises a pipeline stall request until the access completes.

---
 rtl/ram2_ctrl_pkg.sv | 35 +++
 rtl/ram2_ctrl_if.sv | 30 +++
 rtl/ram2_strobe_cnt.sv | 23 ++
 rtl/ram2_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ram2_ctrl_pkg.sv
// Shared types and constants for the RAM2 SRAM bus initiator.
package ram2_ctrl_pkg;

  localparam int InstBusW     = 16;
  localparam int DataBusW     = 16;
  localparam int DataAddrBusW = 16;
  localparam int CntW         = 3;

  // MEM-stage request qualifiers (active-high on the CPU side).
  localparam logic RamChipEnable  = 1'b1;
  localparam logic RamReadEnable  = 1'b1;
  localparam logic RamWriteEnable = 1'b1;

  localparam logic [DataBusW-1:0] ZeroWord = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_t;

  // Counter preload so that a phase lasts exactly n cycles (last flag at 0).
  function automatic logic [CntW-1:0] cyc_load(input int n);
    return CntW'(n - 1);
  endfunction

endpackage

// File: rtl/ram2_ctrl_if.sv
// CPU-side request/response bundle between the pipeline and the RAM2 initiator.
interface ram2_ctrl_if;
  import ram2_ctrl_pkg::*;

  logic [DataAddrBusW-1:0] pc;
  logic                    if_req;
  logic [InstBusW-1:0]     inst;
  logic                    inst_valid;
  logic                    mem_ce;
  logic                    mem_re;
  logic                    mem_we;
  logic [DataAddrBusW-1:0] mem_addr_i;
  logic [DataBusW-1:0]     mem_data_i;
  logic [DataBusW-1:0]     mem_data_o;
  logic                    mem_done;
  logic                    stall_req;

  // Pipeline side issues requests.
  modport master (
    output pc, if_req, mem_ce, mem_re, mem_we, mem_addr_i, mem_data_i,
    input  inst, inst_valid, mem_data_o, mem_done, stall_req
  );

  // Controller side serves them.
  modport slave (
    input  pc, if_req, mem_ce, mem_re, mem_we, mem_addr_i, mem_data_i,
    output inst, inst_valid, mem_data_o, mem_done, stall_req
  );

endinterface

// File: rtl/ram2_strobe_cnt.sv
// Loadable down-counter timing the READ and WR_PULSE phases.
module ram2_strobe_cnt
  import ram2_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  output logic            last
);

  logic [CntW-1:0] cnt;

  // Load on phase entry, then count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/ram2_ctrl.sv
// RAM2 bus initiator: arbitrates IF/MEM requests onto one async SRAM port
// and sequences CE/OE/WE over multiple cycles with registered strobes.
module ram2_ctrl
  import ram2_ctrl_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int RD_CYC = 2,
  parameter int WR_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram2_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] ram2_addr,
  inout  wire  [15:0]       ram2_data,
  output logic              ram2_en_n,
  output logic              ram2_oe_n,
  output logic              ram2_we_n
);

  state_t              state;
  owner_t              owner;
  logic                drive;
  logic [DataBusW-1:0] wdata;
  logic                mem_req;
  logic                cnt_load;
  logic [CntW-1:0]     cnt_val;
  logic                cnt_last;

  assign mem_req = (bus.mem_ce == RamChipEnable) &&
                   ((bus.mem_re == RamReadEnable) || (bus.mem_we == RamWriteEnable));

  // IDLE preloads the read length; WR_SETUP preloads the write pulse length.
  assign cnt_load = (state == ST_IDLE) || (state == ST_WR_SETUP);
  assign cnt_val  = (state == ST_IDLE) ? cyc_load(RD_CYC) : cyc_load(WR_CYC);

  ram2_strobe_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .last     (cnt_last)
  );

  assign ram2_data = drive ? wdata : 'z;

  // Stall until the requester's own completion cycle.
  assign bus.stall_req = (mem_req    && !(state == ST_DONE && owner == OWN_MEM)) ||
                         (bus.if_req && !(state == ST_DONE && owner == OWN_IF));

  // Access sequencer; strobes are set on the edge entering each state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      owner          <= OWN_IF;
      ram2_addr      <= '0;
      ram2_en_n      <= 1'b1;
      ram2_oe_n      <= 1'b1;
      ram2_we_n      <= 1'b1;
      drive          <= 1'b0;
      wdata          <= ZeroWord;
      bus.inst       <= ZeroWord;
      bus.mem_data_o <= ZeroWord;
      bus.inst_valid <= 1'b0;
      bus.mem_done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // MEM beats IF; a write wins over a simultaneous read.
          if (mem_req && bus.mem_we == RamWriteEnable) begin
            state     <= ST_WR_SETUP;
            owner     <= OWN_MEM;
            ram2_addr <= ADDR_W'(bus.mem_addr_i);
            wdata     <= bus.mem_data_i;
            drive     <= 1'b1;
            ram2_en_n <= 1'b0;
          end else if (mem_req) begin
            state     <= ST_READ;
            owner     <= OWN_MEM;
            ram2_addr <= ADDR_W'(bus.mem_addr_i);
            ram2_en_n <= 1'b0;
            ram2_oe_n <= 1'b0;
          end else if (bus.if_req) begin
            state     <= ST_READ;
            owner     <= OWN_IF;
            ram2_addr <= ADDR_W'(bus.pc);
            ram2_en_n <= 1'b0;
            ram2_oe_n <= 1'b0;
          end
        end
        ST_READ: begin
          if (cnt_last) begin
            if (owner == OWN_IF) bus.inst       <= ram2_data;
            else                 bus.mem_data_o <= ram2_data;
            bus.inst_valid <= (owner == OWN_IF);
            bus.mem_done   <= (owner == OWN_MEM);
            ram2_en_n      <= 1'b1;
            ram2_oe_n      <= 1'b1;
            state          <= ST_DONE;
          end
        end
        ST_WR_SETUP: begin
          ram2_we_n <= 1'b0;
          state     <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (cnt_last) begin
            ram2_we_n <= 1'b1;
            state     <= ST_WR_HOLD;
          end
        end
        ST_WR_HOLD: begin
          ram2_en_n    <= 1'b1;
          drive        <= 1'b0;
          bus.mem_done <= 1'b1;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          // Requests are not sampled here, so a held request is not reissued.
          bus.inst_valid <= 1'b0;
          bus.mem_done   <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
